// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB arbiter. ROB_WIDTH and CDB_QUEUE_DEPTH mirror params.v defaults.
// Optional bypass path is enabled with `define CDB_BYPASS_EN.
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif
`ifndef CDB_QUEUE_DEPTH
`define CDB_QUEUE_DEPTH 4
`endif

package cdb_arbiter_pkg;

   localparam int unsigned ROB_W         = `ROB_WIDTH;
   localparam int unsigned CdbQueueDepth = `CDB_QUEUE_DEPTH;

   typedef struct packed {
      logic [ROB_W-1:0] rob_id;
      logic [31:0]      data;
      logic             set_jump_addr;
   } cdb_entry_t;

   typedef enum logic {
      SrcAlu = 1'b0,
      SrcLsb = 1'b1
   } src_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-push and common-data-bus signals between the execution units and the arbiter.
interface cdb_arbiter_if;
   import cdb_arbiter_pkg::*;

   logic             alu_rdy;
   logic [ROB_W-1:0] alu_rob_id;
   logic [31:0]      alu_data;
   logic             alu_set_jump_addr;
   logic             alu_full;

   logic             lsb_rdy;
   logic [ROB_W-1:0] lsb_rob_id;
   logic [31:0]      lsb_data;
   logic             lsb_full;

   logic             cdb_en;
   logic [ROB_W-1:0] cdb_rob_id;
   logic [31:0]      cdb_data;
   logic             cdb_set_jump_addr;

   modport master (
      output alu_rdy, alu_rob_id, alu_data, alu_set_jump_addr,
      output lsb_rdy, lsb_rob_id, lsb_data,
      input  alu_full, lsb_full,
      input  cdb_en, cdb_rob_id, cdb_data, cdb_set_jump_addr
   );

   modport slave (
      input  alu_rdy, alu_rob_id, alu_data, alu_set_jump_addr,
      input  lsb_rdy, lsb_rob_id, lsb_data,
      output alu_full, lsb_full,
      output cdb_en, cdb_rob_id, cdb_data, cdb_set_jump_addr
   );

endinterface

// File: rtl/cdb_queue.sv
// Per-source result FIFO; full depends on occupancy only, so a same-cycle pop never frees a slot.
module cdb_queue
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   en,
   input  logic                   clr,
   input  logic                   push,
   input  cdb_entry_t             push_entry,
   input  logic                   pop,
   output cdb_entry_t             head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   cdb_entry_t      mem [DEPTH];
   logic [PtrW-1:0] rd_ptr;
   logic [PtrW-1:0] wr_ptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == (PtrW + 1)'(DEPTH));
   assign do_push = en && !clr && push && !full;
   assign do_pop  = en && !clr && pop && (count != '0);
   assign head    = mem[rd_ptr];

   // Power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (en && clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter between ALU and LSB result queues driving the registered CDB.
// Define CDB_BYPASS_EN to let an empty source broadcast its input without queueing.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned QUEUE_DEPTH = CdbQueueDepth
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         rdy_in,
   input  logic         flush,
   cdb_arbiter_if.slave bus
);

   localparam int unsigned CntW = $clog2(QUEUE_DEPTH) + 1;

   cdb_entry_t      alu_in, lsb_in, alu_head, lsb_head, win_entry, cdb_q;
   logic [CntW-1:0] alu_count, lsb_count;
   logic            alu_full, lsb_full, alu_empty, lsb_empty;
   logic            alu_acc, lsb_acc, alu_cand, lsb_cand;
   logic            alu_win, lsb_win, alu_byp, lsb_byp;
   logic            cdb_en_q;
   src_e            last_grant;

   assign alu_in = '{rob_id: bus.alu_rob_id, data: bus.alu_data,
                     set_jump_addr: bus.alu_set_jump_addr};
   assign lsb_in = '{rob_id: bus.lsb_rob_id, data: bus.lsb_data, set_jump_addr: 1'b0};

   assign alu_empty = (alu_count == '0);
   assign lsb_empty = (lsb_count == '0);
   assign alu_acc   = rdy_in && !flush && bus.alu_rdy && !alu_full;
   assign lsb_acc   = rdy_in && !flush && bus.lsb_rdy && !lsb_full;

`ifdef CDB_BYPASS_EN
   assign alu_cand = !alu_empty || alu_acc;
   assign lsb_cand = !lsb_empty || lsb_acc;
`else
   assign alu_cand = !alu_empty;
   assign lsb_cand = !lsb_empty;
`endif

   always_comb begin
      alu_win   = alu_cand && (!lsb_cand || last_grant == SrcLsb);
      lsb_win   = lsb_cand && !alu_win;
      // A winner with an empty queue can only be a bypass candidate.
      alu_byp   = alu_win && alu_empty;
      lsb_byp   = lsb_win && lsb_empty;
      win_entry = alu_win ? (alu_byp ? alu_in : alu_head)
                          : (lsb_byp ? lsb_in : lsb_head);
   end

   cdb_queue #(.DEPTH(QUEUE_DEPTH)) u_alu_queue (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .en         (rdy_in),
      .clr        (flush),
      .push       (alu_acc && !alu_byp),
      .push_entry (alu_in),
      .pop        (alu_win && !alu_empty),
      .head       (alu_head),
      .count      (alu_count),
      .full       (alu_full)
   );

   cdb_queue #(.DEPTH(QUEUE_DEPTH)) u_lsb_queue (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .en         (rdy_in),
      .clr        (flush),
      .push       (lsb_acc && !lsb_byp),
      .push_entry (lsb_in),
      .pop        (lsb_win && !lsb_empty),
      .head       (lsb_head),
      .count      (lsb_count),
      .full       (lsb_full)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cdb_q      <= '0;
         cdb_en_q   <= 1'b0;
         last_grant <= SrcLsb;
      end else if (rdy_in) begin
         if (flush) begin
            cdb_en_q   <= 1'b0;
            last_grant <= SrcLsb;
         end else if (alu_win || lsb_win) begin
            cdb_q      <= win_entry;
            cdb_en_q   <= 1'b1;
            last_grant <= alu_win ? SrcAlu : SrcLsb;
         end else begin
            cdb_en_q   <= 1'b0;
         end
      end
   end

   assign bus.alu_full          = alu_full;
   assign bus.lsb_full          = lsb_full;
   assign bus.cdb_en            = cdb_en_q;
   assign bus.cdb_rob_id        = cdb_q.rob_id;
   assign bus.cdb_data          = cdb_q.data;
   assign bus.cdb_set_jump_addr = cdb_q.set_jump_addr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-level reference model predicts each CDB broadcast.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int unsigned QD = 4;

   logic clk = 1'b0;
   logic rst;
   logic rdy;
   logic flush;
   int   n_tests = 0;
   int   n_fail  = 0;

   cdb_arbiter_if bus ();

   cdb_arbiter #(.QUEUE_DEPTH(QD)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .rdy_in (rdy),
      .flush  (flush),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Reference model state: one queue per source plus the expected broadcast stream.
   cdb_entry_t aq[$];
   cdb_entry_t lq[$];
   cdb_entry_t exp_q[$];
   cdb_entry_t exp_e   = '0;
   cdb_entry_t mon_e;
   logic       exp_en  = 1'b0;
   logic       lg_lsb  = 1'b1;   // 1: LSB was granted last, so ALU is preferred

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic model_reset();
      aq.delete();
      lq.delete();
      exp_q.delete();
      exp_en = 1'b0;
      exp_e  = '0;
      lg_lsb = 1'b1;
   endtask

   // One rising edge of the reference model, using the inputs applied before the edge.
   task automatic model_edge();
      cdb_entry_t a_in, l_in;
      logic a_acc, l_acc, a_c, l_c, alu_wins;
      a_in = '{rob_id: bus.alu_rob_id, data: bus.alu_data, set_jump_addr: bus.alu_set_jump_addr};
      l_in = '{rob_id: bus.lsb_rob_id, data: bus.lsb_data, set_jump_addr: 1'b0};
      if (rdy) begin
         if (flush) begin
            aq.delete();
            lq.delete();
            exp_en = 1'b0;
            lg_lsb = 1'b1;
         end else begin
            a_acc = bus.alu_rdy && (aq.size() < QD);
            l_acc = bus.lsb_rdy && (lq.size() < QD);
            a_c   = aq.size() > 0;
            l_c   = lq.size() > 0;
`ifdef CDB_BYPASS_EN
            a_c   = a_c || a_acc;
            l_c   = l_c || l_acc;
`endif
            if (a_c || l_c) begin
               alu_wins = (a_c && l_c) ? lg_lsb : a_c;
               if (alu_wins) begin
                  if (aq.size() > 0) exp_e = aq.pop_front();
                  else begin exp_e = a_in; a_acc = 1'b0; end
               end else begin
                  if (lq.size() > 0) exp_e = lq.pop_front();
                  else begin exp_e = l_in; l_acc = 1'b0; end
               end
               exp_en = 1'b1;
               lg_lsb = !alu_wins;
            end else begin
               exp_en = 1'b0;
            end
            if (a_acc) aq.push_back(a_in);
            if (l_acc) lq.push_back(l_in);
         end
      end
      if (exp_en) exp_q.push_back(exp_e);
   endtask

   task automatic cyc(input logic av, input int aid, input int ad, input logic aj,
                      input logic lv, input int lid, input int ld, input logic r, input logic f);
      bus.alu_rdy           = av;
      bus.alu_rob_id        = ROB_W'(aid);
      bus.alu_data          = ad;
      bus.alu_set_jump_addr = aj;
      bus.lsb_rdy           = lv;
      bus.lsb_rob_id        = ROB_W'(lid);
      bus.lsb_data          = ld;
      rdy                   = r;
      flush                 = f;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
   endtask

   // Monitor: compares flags every cycle and pops one expected entry per expected broadcast.
   always @(negedge clk) begin
      check("alu_full", bus.alu_full, aq.size() == QD);
      check("lsb_full", bus.lsb_full, lq.size() == QD);
      check("cdb_en", bus.cdb_en, exp_en);
      if (exp_en) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL cdb_stream: got broadcast, expected queue empty at %0t", $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("cdb_entry", {bus.cdb_rob_id, bus.cdb_data, bus.cdb_set_jump_addr}, mon_e);
         end
      end
   end

   initial begin
      rst = 1'b1;
      rdy = 1'b0;
      flush = 1'b0;
      bus.alu_rdy = 1'b0; bus.alu_rob_id = '0; bus.alu_data = '0; bus.alu_set_jump_addr = 1'b0;
      bus.lsb_rdy = 1'b0; bus.lsb_rob_id = '0; bus.lsb_data = '0;
      #3;
      check("rst_cdb_en", bus.cdb_en, 1'b0);
      check("rst_alu_full", bus.alu_full, 1'b0);
      check("rst_lsb_full", bus.lsb_full, 1'b0);
      check("rst_cdb_payload", {bus.cdb_rob_id, bus.cdb_data, bus.cdb_set_jump_addr}, 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Single ALU push into an empty block.
      cyc(1, 3, 'h11, 1, 0, 0, 0, 1, 0);
      idle(4);

      // Both sources push together for four cycles: broadcasts alternate.
      for (int i = 0; i < 4; i++) cyc(1, i, 'h100 + i, 0, 1, 8 + i, 'h200 + i, 1, 0);
      idle(9);

      // Sustained pressure from both sources fills the ALU queue; overflow pushes are dropped.
      for (int i = 0; i < 10; i++) cyc(1, i, 'h300 + i, i[0], 1, 8 + (i % 8), 'h400 + i, 1, 0);
      cyc(1, 7, 'h777, 0, 1, 15, 'h4ff, 1, 0);
      idle(25);

      // Flush with entries queued and a broadcast in flight.
      for (int i = 0; i < 3; i++) cyc(1, i, 'h500 + i, 0, 1, 8 + i, 'h600 + i, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(4);

      // rdy_in low for three cycles mid-stream, with pushes offered that must be ignored.
      for (int i = 0; i < 3; i++) cyc(1, i, 'h700 + i, 1, 1, 8 + i, 'h800 + i, 1, 0);
      for (int i = 0; i < 3; i++) cyc(1, 5, 'hdead, 1, 1, 13, 'hbeef, 0, i == 1);
      idle(8);

      // Asynchronous reset between edges with entries queued.
      for (int i = 0; i < 3; i++) cyc(1, i, 'h900 + i, 0, 1, 8 + i, 'ha00 + i, 1, 0);
      #2 rst = 1'b1;
      model_reset();
      #1 check("async_rst_cdb_en", bus.cdb_en, 1'b0);
      #2 rst = 1'b0;
      idle(6);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         cyc($urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom, $urandom,
             $urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0);
      end
      idle(12);

      @(negedge clk);
      #1 check("no_pending_broadcasts", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
